hs_fifo: RTL and testbench

Parametrised valid/ready elastic buffer that decouples a producer (master side) from a consumer (slave side) on one clock. It generalises the fixed 3-bit single-stage master/slave handshake to configurable data width and depth. It adds occupancy reporting, an almost-full watermark and a synchronous flush. It sits between any two handshake endpoints and sustains full throughput (one transfer per cycle) in both directions.

---
 rtl/hs_fifo.sv | 112 +++++++++++
 tb/tb_hs_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hs_fifo.sv
// Single-clock valid/ready elastic buffer with first-word fall-through, occupancy
// reporting, an almost-full watermark and a synchronous flush.
module hs_fifo #(
  parameter int DATA_W   = 3,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              af_q, af_d;
  logic              push_s, pop_s, wr_en_s;

  // Handshakes use only registered ready/valid, so there is no input-to-output path.
  always_comb begin
    push_s  = s_valid & s_ready_q;
    pop_s   = m_valid_q & m_ready;
    wr_en_s = push_s & ~flush;
  end

  // Next-state pointers and occupancy; flush overrides any transfer this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Status flags are computed from the next count so they register alongside it.
  always_comb begin
    s_ready_d = (count_d != CNT_FULL);
    m_valid_d = (count_d != CNT_ZERO);
    af_d      = (count_d >= CNT_AF);
  end

  // Control state with asynchronous reset to the empty condition.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= CNT_ZERO;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      af_q      <= af_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge sys_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign count       = count_q;
  assign almost_full = af_q;
  assign m_data      = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_hs_fifo.sv
// Self-checking bench for hs_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_hs_fifo;

  localparam int DATA_W   = 3;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              flush;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  count;
  logic              almost_full;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] model_q [$];

  hs_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .flush       (flush),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all outputs against the model's view of the current state.
  task automatic check_outputs(input string phase);
    check_eq({phase, ".count"}, 32'(count), 32'(model_q.size()));
    check_eq({phase, ".s_ready"}, 32'(s_ready), 32'(model_q.size() != DEPTH));
    check_eq({phase, ".m_valid"}, 32'(m_valid), 32'(model_q.size() != 0));
    check_eq({phase, ".almost_full"}, 32'(almost_full), 32'(model_q.size() >= AF_LEVEL));
    if (model_q.size() != 0) begin
      check_eq({phase, ".m_data"}, 32'(m_data), 32'(model_q[0]));
    end
  endtask

  // One clock of stimulus: drive, check at the falling edge, advance the model, clock.
  task automatic cycle(input string phase, input logic rst, input logic sv,
                       input logic [DATA_W-1:0] sd, input logic mr, input logic fl);
    bit do_pop;
    bit do_push;
    sys_rst = rst;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    if (rst) model_q.delete();
    @(negedge sys_clk);
    check_outputs(phase);
    do_pop  = (model_q.size() != 0) && mr;
    do_push = sv && (model_q.size() != DEPTH);
    if (!rst) begin
      if (fl) begin
        model_q.delete();
      end else begin
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(sd);
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int p_push;
    int p_pop;

    // Reset then idle
    cycle("reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    cycle("reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    cycle("idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_eq("idle.count_zero", 32'(count), 32'd0);

    // Fill to full, then offer a fifth word that must be refused
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b0);
    cycle("fill_over", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    check_eq("full.count", 32'(count), 32'd4);
    check_eq("full.s_ready", 32'(s_ready), 32'd0);

    // Drain in order; the refused word must never appear
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain.order", 32'(m_data), 32'(i));
      cycle("drain", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    end
    cycle("drained", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Streaming with pointer wrap
    for (int i = 0; i < 8; i++) cycle("stream", 1'b0, 1'b1, DATA_W'(i), 1'b1, 1'b0);
    cycle("stream_tail", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    cycle("stream_end", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Full with simultaneous push and pop: pop only, push lands next cycle
    for (int i = 0; i < 4; i++) cycle("refill", 1'b0, 1'b1, DATA_W'(i + 2), 1'b0, 1'b0);
    cycle("full_pp", 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
    check_eq("full_pp.count", 32'(count), 32'd3);
    cycle("full_push", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    check_eq("full_push.count", 32'(count), 32'd4);

    // Flush with a concurrent offered word
    cycle("pre_flush", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    cycle("pre_flush", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    cycle("flush", 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
    check_eq("flush.m_valid", 32'(m_valid), 32'd0);
    cycle("post_flush", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    cycle("pre_rst", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    cycle("pre_rst", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    sys_rst = 1'b1;
    s_valid = 1'b0;
    #2;
    check_eq("async_rst.m_valid", 32'(m_valid), 32'd0);
    check_eq("async_rst.count", 32'(count), 32'd0);
    check_eq("async_rst.s_ready", 32'(s_ready), 32'd1);
    cycle("in_rst", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    cycle("post_rst", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    cycle("post_rst", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

    // Randomized traffic in three pressure regimes
    for (int ph = 0; ph < 3; ph++) begin
      p_push = (ph == 1) ? 30 : 80;
      p_pop  = (ph == 0) ? 30 : 80;
      for (int i = 0; i < 1000; i++) begin
        cycle("rand",
              $urandom_range(0, 299) == 0,
              $urandom_range(0, 99) < p_push,
              DATA_W'($urandom),
              $urandom_range(0, 99) < p_pop,
              $urandom_range(0, 63) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
